// File: rtl/rc4_new_design.sv
// rc4_new_design -- RC4 keystream generator.
//
// Each run goes through four phases. It fills the S-box with the identity
// permutation, then runs the key schedule, then produces NUMS_OF_BYTES
// keystream bytes. It then holds the results with done=1 until start drops.
// Each S-box step (one swap) takes one clock cycle, so S is a register array.
// A block RAM would need several cycles per swap.
//
// Parameters:
//   NUMS_OF_BYTES  keystream bytes per run (1..16)
// Ports:
//   clk         clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   start       run request, level-sampled while idle
//   key         key bytes, byte n = key[8n+7:8n], byte 0 used first
//   key_length  key length in bytes; anything outside 1..4 means 4
//   k_addr      lane n = S-box index t that produced keystream byte n
//   ckey        lane n = keystream byte n
//   done        high while ckey/k_addr hold a finished result
// Configuration macro:
//   RC4_KADDR_EN  when defined, k_addr is registered and driven. When it is
//                 not defined, k_addr is tied to zero.
module rc4_new_design #(
    parameter int NUMS_OF_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [31:0]                key,
    input  logic [7:0]                 key_length,
    output logic [NUMS_OF_BYTES*8-1:0] k_addr,
    output logic [NUMS_OF_BYTES*8-1:0] ckey,
    output logic                       done
);

    typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} state_t;

    state_t state, state_next;

    logic [7:0]                 sbox [256];
    logic [7:0]                 i_idx, j_idx;
    logic [31:0]                key_lat;
    logic [2:0]                 len_lat;
    logic [1:0]                 key_pos;     // i mod L, kept as a wrapping counter
    logic [4:0]                 lane;
    logic [NUMS_OF_BYTES*8-1:0] ckey_q;

    // Datapath for one swap step, shared by KSA and PRGA.
    logic [7:0] i_plus, rd_i, s_i, key_byte, j_new, s_j, t_idx, s_t;
    logic [2:0] len_eff;

    always_comb begin
        i_plus   = i_idx + 8'd1;
        rd_i     = (state == PRGA) ? i_plus : i_idx;
        s_i      = sbox[rd_i];
        key_byte = key_lat[{key_pos, 3'b000} +: 8];
        j_new    = j_idx + s_i + ((state == KSA) ? key_byte : 8'd0);
        s_j      = sbox[j_new];
        t_idx    = s_i + s_j;
        // Read S[t] as it will be after this cycle's swap. The array is only
        // updated at the clock edge, so the two swapped entries are bypassed.
        if (t_idx == rd_i)
            s_t = s_j;
        else if (t_idx == j_new)
            s_t = s_i;
        else
            s_t = sbox[t_idx];
        len_eff = (key_length >= 8'd1 && key_length <= 8'd4) ? key_length[2:0] : 3'd4;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = INIT;
            INIT: if (i_idx == 8'd255) state_next = KSA;
            KSA:  if (i_idx == 8'd255) state_next = PRGA;
            PRGA: if (lane == 5'(NUMS_OF_BYTES - 1)) state_next = DONE;
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The S-box contents after reset do not matter, so S has no reset.
    // When i==j both writes store the same value, so their order is irrelevant.
    always_ff @(posedge clk) begin
        case (state)
            INIT: sbox[i_idx] <= i_idx;
            KSA, PRGA: begin
                sbox[rd_i]  <= s_j;
                sbox[j_new] <= s_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx   <= 8'd0;
            j_idx   <= 8'd0;
            key_lat <= 32'd0;
            len_lat <= 3'd4;
            key_pos <= 2'd0;
            lane    <= 5'd0;
            ckey_q  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key_lat <= key;
                    len_lat <= len_eff;
                    i_idx   <= 8'd0;
                    j_idx   <= 8'd0;
                    key_pos <= 2'd0;
                    lane    <= 5'd0;
                    ckey_q  <= '0;
                end
                INIT: i_idx <= i_idx + 8'd1;   // wraps to 0 for the key schedule
                KSA: begin
                    i_idx   <= i_idx + 8'd1;   // wraps to 0 for keystream output
                    j_idx   <= (i_idx == 8'd255) ? 8'd0 : j_new;
                    key_pos <= ({1'b0, key_pos} == len_lat - 3'd1) ? 2'd0 : key_pos + 2'd1;
                end
                PRGA: begin
                    i_idx                     <= i_plus;
                    j_idx                     <= j_new;
                    ckey_q[{lane, 3'b000} +: 8] <= s_t;
                    lane                      <= lane + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef RC4_KADDR_EN
    logic [NUMS_OF_BYTES*8-1:0] kaddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            kaddr_q <= '0;
        else if (state == IDLE && start)
            kaddr_q <= '0;
        else if (state == PRGA)
            kaddr_q[{lane, 3'b000} +: 8] <= t_idx;
    end

    assign k_addr = kaddr_q;
`else
    assign k_addr = '0;
`endif

    assign ckey = ckey_q;
    assign done = (state == DONE);

endmodule

// File: tb/tb_rc4_new_design.sv
// Testbench for rc4_new_design. It checks the design against a software RC4
// model and uses random keys, lengths and inputs that change while a run is
// in progress.
module tb_rc4_new_design;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [31:0]    key;
    logic [7:0]     key_length;
    logic [N*8-1:0] k_addr;
    logic [N*8-1:0] ckey;
    logic           done;

    int compared = 0;
    int mismatched = 0;

    // Expectations the checker applies on every falling edge.
    bit             chk_en   = 1'b0;
    bit             exp_done = 1'b0;
    bit             exp_zero = 1'b1;
    logic [N*8-1:0] exp_ckey = '0;
    logic [N*8-1:0] exp_kaddr = '0;

    rc4_new_design #(.NUMS_OF_BYTES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .key_length(key_length), .k_addr(k_addr), .ckey(ckey), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Software RC4 reference: the key schedule, then N output bytes.
    task automatic rc4_model(input logic [31:0] k, input logic [7:0] kl,
                             output logic [N*8-1:0] ks, output logic [N*8-1:0] ta);
        int s[256];
        int len, ii, jj, tmp, t;
        len = (kl >= 1 && kl <= 4) ? int'(kl) : 4;
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + int'((k >> (8 * (x % len))) & 32'hFF)) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ii = 0; jj = 0;
        ks = '0; ta = '0;
        for (int n = 0; n < N; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            t = (s[ii] + s[jj]) % 256;
            ks[8*n +: 8] = 8'(s[t]);
            ta[8*n +: 8] = 8'(t);
        end
    endtask

    // One compare process for all cycles.
    always @(negedge clk) begin
        if (chk_en) begin
            check("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                check("ckey", 64'(ckey), 64'(exp_ckey));
`ifdef RC4_KADDR_EN
                check("k_addr", 64'(k_addr), 64'(exp_kaddr));
`endif
            end else if (exp_zero) begin
                check("ckey_zero", 64'(ckey), 64'd0);
`ifdef RC4_KADDR_EN
                check("k_addr_zero", 64'(k_addr), 64'd0);
`endif
            end
`ifndef RC4_KADDR_EN
            check("k_addr_off", 64'(k_addr), 64'd0);
`endif
        end
    end

    // One complete run with start held high. Inputs may be scrambled while the
    // run is in progress. After the hold period, start drops for one edge.
    task automatic do_run(input logic [31:0] k, input logic [7:0] kl, input int hold,
                          input bit scramble, input bit use_lit, input logic [31:0] lit);
        logic [N*8-1:0] ks, ta;
        rc4_model(k, kl, ks, ta);
        @(negedge clk);
        key = k; key_length = kl; start = 1'b1;
        exp_ckey = ks;
        exp_kaddr = ta;
        @(posedge clk); #1;                       // edge that samples start
        exp_zero = 1'b1;
        for (int c = 1; c <= 512 + N; c++) begin
            @(posedge clk); #1;
            if (c == 513) exp_zero = 1'b0;         // first keystream lane written
            if (c == 512 + N) exp_done = 1'b1;
            if (scramble) begin
                key = $urandom;
                key_length = 8'($urandom);
            end
        end
        if (use_lit) check("ckey_literal", 64'(ckey), 64'(lit));
        $display("run key=%h len=%0d ckey=%h k_addr=%h expected=%h", k, kl, ckey, k_addr, ks);
        repeat (hold) @(posedge clk);             // start still high: no rerun
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        exp_done = 1'b0;
    endtask

    // A run that is cut short by a reset after abort_at cycles.
    task automatic aborted_run(input logic [31:0] k, input logic [7:0] kl, input int abort_at);
        @(negedge clk);
        key = k; key_length = kl; start = 1'b1;
        @(posedge clk); #1;
        exp_zero = 1'b1;
        repeat (abort_at) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_done_async", 64'(done), 64'd0);
        check("rst_ckey_async", 64'(ckey), 64'd0);
        check("rst_kaddr_async", 64'(k_addr), 64'd0);
        $display("reset mid-run after %0d cycles: done=%b ckey=%h", abort_at, done, ckey);
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N*8-1:0] ks, ta;
        logic [31:0] rk;
        logic [7:0] rl;

        // The hand-computed RC4 vectors check the model itself.
        rc4_model(32'h696B6957, 8'd4, ks, ta);
        check("model_wiki", 64'(ks), 64'h6DDB4460);
        rc4_model(32'h0079654B, 8'd3, ks, ta);
        check("model_key", 64'(ks), 64'h81779FEB);

        rst_n = 1'b0; start = 1'b0; key = '0; key_length = '0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(32'h696B6957, 8'd4, 20, 1'b0, 1'b1, 32'h6DDB4460);   // "Wiki", long hold
        do_run(32'h696B6957, 8'd4, 0, 1'b1, 1'b1, 32'h6DDB4460);    // rerun after one low cycle
        do_run(32'hAB79654B, 8'd3, 2, 1'b1, 1'b1, 32'h81779FEB);    // "Key", upper byte junk
        do_run(32'h696B6957, 8'd0, 1, 1'b0, 1'b1, 32'h6DDB4460);    // length 0 -> 4
        do_run(32'h696B6957, 8'd9, 1, 1'b0, 1'b1, 32'h6DDB4460);    // length 9 -> 4
        for (int r = 0; r < 6; r++) begin
            rk = $urandom;
            rl = (r % 2 == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom);
            do_run(rk, rl, int'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0);
        end
        aborted_run(32'h696B6957, 8'd4, 300);                          // during key schedule
        do_run(32'h696B6957, 8'd4, 1, 1'b0, 1'b1, 32'h6DDB4460);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
